// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - multicycle MIPS multiply/divide unit with HI/LO registers
//
// Runs MULT, MULTU, DIV and DIVU one bit per clock over N iterations and keeps
// the results in the architectural HI/LO registers.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, op, a, b   operation request (sampled only while idle); op: 00 MULT,
//                     01 MULTU, 10 DIV, 11 DIVU; a = rs, b = rt
//   hi_we, lo_we      MTHI / MTLO write enables (honoured only while idle)
//   wr_data           MTHI / MTLO write data
//   busy              registered, high while an operation is in progress
//   done              registered one-cycle pulse, HI/LO valid with it
//   div_by_zero       last completed operation was a divide by zero
//   hi, lo            HI and LO registers (read directly by MFHI / MFLO)
module mips_muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state;
    state_t state_next;

    logic            is_div_q;   // operation in flight is a divide
    logic            neg_res;    // negate product / quotient in FIX
    logic            neg_rem;    // negate remainder in FIX
    logic            zdiv;       // divide by zero detected at start
    logic [N-1:0]    opnd;       // multiplicand (multiply) or divisor (divide)
    logic [2*N-1:0]  acc;        // {upper, lower} working register
    logic [CW-1:0]   cnt;

    // Operand conditioning at start; op[0]=0 selects the signed variants.
    logic         signed_op;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;
    logic         b_zero;

    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && a[N-1]) ? -a : a;
    assign b_mag     = (signed_op && b[N-1]) ? -b : b;
    assign b_zero    = (b == '0);

    // Multiply step: acc holds {partial product, remaining multiplier bits};
    // add the multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole register right, catching the carry at the top.
    logic [N-1:0]   mul_addend;
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;

    assign mul_addend = acc[0] ? opnd : '0;
    assign mul_sum    = {1'b0, acc[2*N-1:N]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc[N-1:1]};

    // Restoring divide step: acc holds {remainder, dividend bits / quotient}.
    // The shifted partial remainder is N+1 bits wide; the extra bit is the
    // guard that keeps the trial subtraction exact for divisors near 2^N.
    logic [N:0]     div_shift;
    logic [N:0]     div_diff;
    logic [2*N-1:0] div_next;

    assign div_shift = acc[2*N-1:N-1];
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_next  = div_diff[N] ? {acc[2*N-2:0], 1'b0}
                                   : {div_diff[N-1:0], acc[N-2:0], 1'b1};

    // Sign fix-up of the finished magnitudes.
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix;
    logic [N-1:0]   rem_fix;

    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -acc[N-1:0] : acc[N-1:0];
    assign rem_fix  = neg_rem ? -acc[2*N-1:N] : acc[2*N-1:N];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (op[1] && b_zero) ? FIX : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            is_div_q    <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            zdiv        <= 1'b0;
            opnd        <= '0;
            acc         <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FIX);
            case (state)
                IDLE: begin
                    // MTHI/MTLO land even alongside an accepted start; the
                    // result written in FIX then takes precedence.
                    if (hi_we) begin
                        hi <= wr_data;
                    end
                    if (lo_we) begin
                        lo <= wr_data;
                    end
                    if (start) begin
                        cnt      <= '0;
                        is_div_q <= op[1];
                        zdiv     <= op[1] & b_zero;
                        neg_res  <= signed_op & (a[N-1] ^ b[N-1]);
                        neg_rem  <= signed_op & a[N-1];
                        if (op[1]) begin
                            opnd <= b_mag;
                            acc  <= {{N{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{N{1'b0}}, b_mag};
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div_q ? div_next : mul_next;
                end
                FIX: begin
                    if (zdiv) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        div_by_zero <= 1'b0;
                        if (is_div_q) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - scoreboard bench for mips_muldiv_unit (N=32 and N=8)
module tb_mips_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start32, hi_we32, lo_we32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, wr32;
    logic        busy32, done32, dbz32;
    logic [31:0] hi32, lo32;

    logic        start8, hi_we8, lo_we8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wr8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    mips_muldiv_unit #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .hi_we(hi_we32), .lo_we(lo_we32), .wr_data(wr32),
        .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
    );

    mips_muldiv_unit #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(hi_we8), .lo_we(lo_we8), .wr_data(wr8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        string       nm;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] last_hi;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    exp_t e32, e8;
    always @(negedge clk) begin
        if (!rst && done32) begin
            n_vec++;
            if (q32.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done32 actual=done required=no_done");
            end else begin
                e32 = q32.pop_front();
                if (hi32 !== e32.hi || lo32 !== e32.lo || dbz32 !== e32.dbz) begin
                    n_err++;
                    $display("FAIL %s actual hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b",
                             e32.nm, hi32, lo32, dbz32, e32.hi, e32.lo, e32.dbz);
                end
            end
        end
        if (!rst && done8) begin
            n_vec++;
            if (q8.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done8 actual=done required=no_done");
            end else begin
                e8 = q8.pop_front();
                if ({24'b0, hi8} !== e8.hi || {24'b0, lo8} !== e8.lo || dbz8 !== e8.dbz) begin
                    n_err++;
                    $display("FAIL %s actual hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b",
                             e8.nm, hi8, lo8, dbz8, e8.hi[7:0], e8.lo[7:0], e8.dbz);
                end
            end
        end
    end

    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ez,
                         input int lat, input logic start_we, input logic [31:0] we_data,
                         input int restart_at, input int hiwe_at, input int rst_at,
                         input string nm);
        int edges;
        int busy_cnt;
        bit got;
        @(negedge clk);
        op32 = o; a32 = x; b32 = y; start32 = 1'b1;
        if (start_we) begin
            hi_we32 = 1'b1;
            wr32    = we_data;
        end
        if (rst_at < 0) q32.push_back('{eh, el, ez, nm});
        @(posedge clk); #1;
        start32 = 1'b0; hi_we32 = 1'b0;
        edges = 0; got = 0;
        busy_cnt = busy32 ? 1 : 0;
        while (!got && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            start32 = 1'b0; hi_we32 = 1'b0;
            if (edges == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk({nm, "_busy_after_rst"}, {63'b0, busy32}, 64'd0);
                chk({nm, "_done_after_rst"}, {63'b0, done32}, 64'd0);
                chk({nm, "_hi_after_rst"}, {32'b0, hi32}, 64'd0);
                chk({nm, "_lo_after_rst"}, {32'b0, lo32}, 64'd0);
                rst = 1'b0;
                last_hi = 32'h0;
                return;
            end
            if (edges == hiwe_at + 1) chk({nm, "_hi_we_ignored"}, {32'b0, hi32}, {32'b0, last_hi});
            if (done32) got = 1;
            else if (busy32) busy_cnt++;
            if (edges == restart_at) begin
                start32 = 1'b1; op32 = 2'b11; a32 = 32'h5; b32 = 32'h0;
            end
            if (edges == hiwe_at) begin
                hi_we32 = 1'b1; wr32 = 32'hDEADBEEF;
            end
        end
        start32 = 1'b0; hi_we32 = 1'b0;
        chk({nm, "_latency"}, 64'(edges), 64'(lat));
        chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
        @(posedge clk); #1;
        chk({nm, "_idle_after_done"}, {63'b0, busy32}, 64'd0);
        last_hi = eh;
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] eh, input logic [7:0] el, input int lat,
                        input string nm);
        int edges;
        bit got;
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back('{{24'b0, eh}, {24'b0, el}, 1'b0, nm});
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0; got = 0;
        while (!got && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (done8) got = 1;
        end
        chk({nm, "_latency"}, 64'(edges), 64'(lat));
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        hi_we32 = h; lo_we32 = l; wr32 = d;
        @(negedge clk);
        hi_we32 = 1'b0; lo_we32 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start32 = 0; hi_we32 = 0; lo_we32 = 0; op32 = 0; a32 = 0; b32 = 0; wr32 = 0;
        start8 = 0; hi_we8 = 0; lo_we8 = 0; op8 = 0; a8 = 0; b8 = 0; wr8 = 0;
        last_hi = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'b0, busy32}, 64'd0);
        chk("reset_done", {63'b0, done32}, 64'd0);
        chk("reset_dbz", {63'b0, dbz32}, 64'd0);
        chk("reset_hi", {32'b0, hi32}, 64'd0);
        chk("reset_lo", {32'b0, lo32}, 64'd0);
        rst = 1'b0;

        run8(2'b00, 8'h80, 8'h80, 8'h40, 8'h00, 9, "mult8_80x80");
        run8(2'b10, 8'h80, 8'h03, 8'hFE, 8'hD6, 9, "div8_80by3");

        run32(2'b00, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 1'b0, 32'h0, -1, -1, -1, "mult_m3x5");
        run32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0, 32'h0, -1, -1, -1, "multu_max");
        run32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 33, 1'b0, 32'h0, -1, -1, -1, "mult_m1xm1");
        run32(2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0, 32'h0, -1, -1, -1, "div_m7by2");
        run32(2'b11, 32'hFFFFFFF9, 32'h2, 32'h1, 32'h7FFFFFFC, 1'b0, 33, 1'b0, 32'h0, -1, -1, -1, "divu_fff9by2");

        mt(1'b1, 1'b1, 32'h55);
        chk("mt_both_hi", {32'b0, hi32}, 64'h55);
        chk("mt_both_lo", {32'b0, lo32}, 64'h55);
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        chk("mthi", {32'b0, hi32}, 64'h11);
        chk("mtlo", {32'b0, lo32}, 64'h22);

        run32(2'b11, 32'h7, 32'h0, 32'h11, 32'h22, 1'b1, 1, 1'b0, 32'h0, -1, -1, -1, "divu_7by0");
        run32(2'b11, 32'h5, 32'h0, 32'h33, 32'h22, 1'b1, 1, 1'b1, 32'h33, -1, -1, -1, "divu_5by0_mthi");
        run32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 1'b0, 32'h0, -1, -1, -1, "div_overflow");
        run32(2'b01, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, 33, 1'b0, 32'h0, 10, 12, -1, "multu_restart_hiwe");
        run32(2'b10, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 33, 1'b0, 32'h0, -1, -1, 15, "div_rst_abort");
        repeat (5) @(posedge clk);
        #1;
        run32(2'b11, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 33, 1'b0, 32'h0, -1, -1, -1, "divu_100by7");

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard32_empty", 64'(q32.size()), 64'd0);
        chk("scoreboard8_empty", 64'(q8.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
